// File: rtl/ripple_count_sampler.sv
// rtl/ripple_count_sampler.sv - samples a 4-bit ripple count, filters transients, accumulates deltas over a window
module ripple_count_sampler #(
    parameter bit DOWN       = 1'b0,
    parameter int STABLE_CYC = 2,
    parameter int WIN_CYC    = 1000,
    parameter int TOT_W      = 16
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [3:0]       cnt_in,
    input  logic             start,
    input  logic             abort,
    output logic [TOT_W-1:0] total,
    output logic             delta_valid,
    output logic             busy,
    output logic             done,
    output logic             ovf
);
    localparam int               WIN_W    = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam logic [3:0]       STAB_MAX = 4'(STABLE_CYC);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       s1, s2, last, stab_cnt, delta;
    logic             acc_seen, changing, stable, acc;
    logic             start_ok, arm_load, meas_step, win_end;
    logic [WIN_W-1:0] win;
    logic [TOT_W:0]   sum;

    // s1 != s2 means s2 takes a new value at the coming edge
    assign changing = (s1 != s2);
    assign stable   = (stab_cnt == STAB_MAX);
    assign acc      = stable && !acc_seen;
    assign delta    = DOWN ? (last - s2) : (s2 - last);
    assign sum      = {1'b0, total} + (TOT_W+1)'(delta);
    assign win_end  = (win == WIN_LAST);
    assign busy     = (state_q == S_ARM) || (state_q == S_MEAS);

    always_comb begin
        state_d   = state_q;
        start_ok  = 1'b0;
        arm_load  = 1'b0;
        meas_step = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d  = S_ARM;
                    start_ok = 1'b1;
                end
            end
            S_ARM: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (stable) begin
                    // an already-settled value serves as the reference
                    state_d  = S_MEAS;
                    arm_load = 1'b1;
                end
            end
            S_MEAS: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    meas_step = 1'b1;
                    if (win_end) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q     <= S_IDLE;
            s1          <= 4'd0;
            s2          <= 4'd0;
            stab_cnt    <= 4'd0;
            acc_seen    <= 1'b0;
            last        <= 4'd0;
            win         <= '0;
            total       <= '0;
            delta_valid <= 1'b0;
            done        <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1          <= cnt_in;
            s2          <= s1;
            delta_valid <= 1'b0;
            done        <= 1'b0;

            if (changing) begin
                stab_cnt <= 4'd1;
                acc_seen <= 1'b0;
            end else begin
                if (stab_cnt != STAB_MAX) begin
                    stab_cnt <= stab_cnt + 4'd1;
                end
                if (stable) begin
                    acc_seen <= 1'b1;
                end
            end

            if (start_ok) begin
                total <= '0;
                ovf   <= 1'b0;
                win   <= '0;
            end

            if (arm_load) begin
                last <= s2;
            end

            if (meas_step) begin
                win <= win + WIN_W'(1);
                if (acc) begin
                    last <= s2;
                    if (delta != 4'd0) begin
                        delta_valid <= 1'b1;
                        if (sum[TOT_W]) begin
                            total <= '1;
                            ovf   <= 1'b1;
                        end else begin
                            total <= sum[TOT_W-1:0];
                        end
                    end
                end
                if (win_end) begin
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/ripple_count_sampler.md
Name: ripple_count_sampler

Overview:
- Synchronous consumer stage placed directly downstream of the 4-bit asynchronous ripple counters.
- Brings the free-running 4-bit ripple count into the system clock domain and rejects ripple-settling transients.
- Converts successive stable samples into modulo-16 deltas and accumulates them over a programmable measurement window.
- Reports the total event count for the window, with saturation and completion flags.

Parameters:
- DOWN, 0: count direction of the upstream counter. 0 means delta = new - last (mod 16); 1 means delta = last - new (mod 16).
- STABLE_CYC, 2: number of consecutive identical synchronized samples required before a value is accepted. Legal range 1..15.
- WIN_CYC, 1000: measurement window length in clk cycles, counted from entry into MEAS. Must be at least 1.
- TOT_W, 16: width of the accumulated total.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- res_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- cnt_in  in  4  raw ripple-counter value; asynchronous to clk.
- start  in  1  single-cycle request to begin a measurement; honoured only in IDLE or DONE.
- abort  in  1  returns the FSM to IDLE next cycle; result outputs keep their current values.
- total  out  TOT_W  accumulated event count for the current or last window.
- delta_valid  out  1  one-cycle pulse when a nonzero delta is added to total.
- busy  out  1  high in ARM and MEAS.
- done  out  1  one-cycle pulse on entry to DONE.
- ovf  out  1  sticky; set when total saturates, cleared on the next accepted start.

Behaviour:
- Reset values (res_n=0 at a clk edge): sync flops=0, stable counter=0, last=0, total=0, delta_valid=0, busy=0, done=0, ovf=0, state=IDLE. Reset has priority over abort and start.
- Synchronizer: two flops, s1 then s2. cnt_in reaches s2 two edges after it becomes steady.
- Stability filter:
  - stab_cnt resets to 1 whenever s2 differs from its previous-cycle value; otherwise it increments and saturates at STABLE_CYC.
  - "acc" is asserted in a cycle where stab_cnt first reaches STABLE_CYC for a given value; asserted once per distinct stable value.
  - With STABLE_CYC=1, every change of s2 produces acc.
- FSM states: IDLE, ARM, MEAS, DONE.
  - IDLE: busy=0. start moves to ARM; on that edge total is cleared to 0, ovf is cleared, and the window counter is cleared.
  - ARM: waits for the first acc; loads last=s2 and moves to MEAS. No accumulation in ARM. A stable s2 already present counts as acc in the first ARM cycle.
  - MEAS: the window counter increments every cycle. On acc, delta=(DOWN ? last-s2 : s2-last) mod 16 and last=s2.
    - If delta is nonzero: total=min(total+delta, 2^TOT_W-1) and delta_valid pulses in the following cycle.
    - If the saturation clamp applies: ovf=1.
    - When the window counter reaches WIN_CYC-1, the FSM moves to DONE. An acc in that final cycle is still accumulated.
  - DONE: done=1 for exactly the entry cycle; total is held. start behaves as it does in IDLE.
- abort in ARM or MEAS goes to IDLE next cycle; total and ovf are frozen at their current values and done does not pulse. If start and abort are high in the same cycle, abort wins.
- Wrap-around: a transition 15->0 with DOWN=0 gives delta=1; 0->15 with DOWN=1 gives delta=1.
- More than 15 events between two accepted samples alias and are not detected; the upstream rate must be below clk/(2+STABLE_CYC)/15 per event.
- start while busy is ignored.

Test Plan:
- Reset mid-MEAS with total=37: drive res_n=0 for 1 cycle -> all outputs 0 and state IDLE on the next edge; cnt_in changes afterwards are not accumulated.
- DOWN=0, STABLE_CYC=2, WIN_CYC=200: start, cnt_in steps 3,4,5,...,15,0,1,2 with each value held 8 cycles -> total=15, done pulses once, 15 delta_valid pulses, ovf=0.
- Glitch rejection: cnt_in stable 6, then a 1-cycle glitch to 4, then 7 held -> exactly one delta of 1 accepted (6->7); no delta for the value 4.
- DOWN=1: cnt_in steps 2,1,0,15,14 -> total=4, including the wrap delta 0->15 of 1.
- Saturation with TOT_W=4: 20 events in the window -> total=15, ovf=1; a following start clears ovf and total to 0.
- Abort: start, then after 3 events assert abort together with start -> IDLE next cycle, total=3 held, done never pulses, busy=0.
